v2f_seq_divmod: RTL and testbench

// - Multi-cycle signed/unsigned divider producing quotient and remainder together.
// - Sits upstream of the v2f arithmetic/compare primitives: it turns wide / and % into a

---
 rtl/v2f_seq_divmod.sv | 168 ++++++++++++++++
 tb/tb_v2f_seq_divmod.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/v2f_seq_divmod.sv
// Multi-cycle restoring divider: signed/unsigned quotient and remainder with valid/ready handshakes.
// Optional build macro V2F_DIVMOD_EARLY_EXIT_EN: skip leading zeros of |a| and short-circuit |a|<|b|.
module v2f_seq_divmod #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;        // dividend, consumed MSB-first
   logic [WIDTH-1:0] dvs;        // divisor magnitude
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] part_quo;
   logic             q_neg;
   logic             r_neg;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             q_bit;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] fin_quot;
   logic [WIDTH-1:0] fin_rem;

   // Operand magnitudes; with SIGNED=0 the sign flags are constant 0 and the negators vanish.
   always_comb begin
      a_neg = SIGNED && a[WIDTH-1];
      b_neg = SIGNED && b[WIDTH-1];
      a_mag = a_neg ? (~a + WIDTH'(1)) : a;
      b_mag = b_neg ? (~b + WIDTH'(1)) : b;
   end

   // One restoring step: the borrow out of the trial subtract decides the quotient bit.
   always_comb begin
      shifted  = {part_rem, dvd[WIDTH-1]};
      diff     = shifted - {1'b0, dvs};
      q_bit    = ~diff[WIDTH];
      step_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      step_quo = {part_quo[WIDTH-2:0], q_bit};
      fin_quot = q_neg ? (~step_quo + WIDTH'(1)) : step_quo;
      fin_rem  = r_neg ? (~step_rem + WIDTH'(1)) : step_rem;
   end

`ifdef V2F_DIVMOD_EARLY_EXIT_EN
   int a_msb;

   function automatic int msb_index(input logic [WIDTH-1:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

   always_comb begin
      a_msb = msb_index(a_mag);
   end
`endif

   // Accept only out of IDLE and never while reset is asserted.
   assign in_ready = (state == IDLE) && !rst;

   // NOTE: working registers carry no reset; they are always loaded on accept before being
   // read, so only the FSM and the visible outputs need a known reset value.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         q_neg    <= a_neg ^ b_neg;
         r_neg    <= a_neg;
         dvs      <= b_mag;
         part_rem <= '0;
         part_quo <= '0;
`ifdef V2F_DIVMOD_EARLY_EXIT_EN
         cnt      <= CW'(a_msb + 1);
         dvd      <= a_mag << (WIDTH - 1 - a_msb);
`else
         cnt      <= CW'(WIDTH);
         dvd      <= a_mag;
`endif
      end else if (state == CALC) begin
         part_rem <= step_rem;
         part_quo <= step_quo;
         dvd      <= {dvd[WIDTH-2:0], 1'b0};
         cnt      <= cnt - CW'(1);
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         quot      <= '0;
         rem       <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (b == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     quot      <= '0;
                     rem       <= '0;
                     div_zero  <= 1'b1;
`ifdef V2F_DIVMOD_EARLY_EXIT_EN
                  end else if (a_mag < b_mag) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     quot      <= '0;
                     rem       <= a;
                     div_zero  <= 1'b0;
`endif
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               // Last step: results are sign-corrected on the way into the output registers.
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  quot      <= fin_quot;
                  rem       <= fin_rem;
                  div_zero  <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_v2f_seq_divmod.sv
// Self-checking bench for v2f_seq_divmod (WIDTH=32, SIGNED=1): directed cases plus random
// operands compared against a plain-arithmetic reference model; honours V2F_DIVMOD_EARLY_EXIT_EN.
module tb_v2f_seq_divmod;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quot;
   logic [W-1:0] rem;
   logic         div_zero;

   int checks   = 0;
   int failures = 0;

   v2f_seq_divmod #(.WIDTH(W), .SIGNED(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: language-level signed / and %, with the divide-by-zero and overflow rules.
   function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb);
      exp_t              e;
      logic signed [W-1:0] x;
      logic signed [W-1:0] y;
      logic [W-1:0]      ax;
      logic [W-1:0]      ay;
      int                msb;
      x = xa;
      y = xb;
      if (y == 0) begin
         e.q = '0; e.r = '0; e.dz = 1'b1; e.lat = 1;
         return e;
      end
      e.dz = 1'b0;
      if (x == 32'sh8000_0000 && y == -32'sd1) begin
         e.q = 32'h8000_0000;
         e.r = '0;
      end else begin
         e.q = x / y;
         e.r = x % y;
      end
      ax = x[W-1] ? -x : x;
      ay = y[W-1] ? -y : y;
      msb = 0;
      for (int i = 0; i < W; i++) if (ax[i]) msb = i;
`ifdef V2F_DIVMOD_EARLY_EXIT_EN
      e.lat = (ax < ay) ? 1 : msb + 2;
`else
      e.lat = W + 1;
`endif
      return e;
   endfunction

   // Present one operation, measure latency, check result; with out_ready high also check the release.
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input string tag);
      exp_t e;
      int   w;
      int   lat;
      e = model(xa, xb);
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({tag, ".ready"}, W'(in_ready), W'(1));
      a        = xa;
      b        = xb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 200);
      check({tag, ".latency"}, W'(lat), W'(e.lat));
      check({tag, ".quot"}, quot, e.q);
      check({tag, ".rem"}, rem, e.r);
      check({tag, ".div_zero"}, W'(div_zero), W'(e.dz));
      check({tag, ".busy"}, W'(in_ready), W'(0));
      if (out_ready) begin
         @(negedge clk);
         check({tag, ".released"}, W'(out_valid), W'(0));
         check({tag, ".idle"}, W'(in_ready), W'(1));
      end
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;

      // Reset state
      @(negedge clk);
      check("rst.in_ready", W'(in_ready), W'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.out_valid", W'(out_valid), W'(0));
      check("rst.quot", quot, W'(0));
      check("rst.rem", rem, W'(0));
      check("rst.div_zero", W'(div_zero), W'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst.in_ready", W'(in_ready), W'(1));

      // Directed sign, zero and overflow cases
      run_op(32'd100, 32'd7, "pp");
      check("pp.quot_abs", quot, 32'd14);
      run_op(-32'sd100, 32'd7, "np");
      run_op(32'd100, -32'sd7, "pn");
      run_op(-32'sd100, -32'sd7, "nn");
      run_op(32'd5, 32'd0, "div0");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, "intmin");
      run_op(32'd3, 32'd9, "small");
      run_op(32'hFFFF_FFFF, 32'd1, "neg1_by_1");
      run_op(32'h7FFF_FFFF, 32'd1, "max_by_1");

      // Backpressure: result held, new operands ignored
      out_ready = 1'b0;
      run_op(32'd100, 32'd7, "bp");
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         a        = 32'd1;
         b        = 32'd1;
         @(negedge clk);
         check("bp.out_valid", W'(out_valid), W'(1));
         check("bp.quot", quot, 32'd14);
         check("bp.rem", rem, 32'd2);
         check("bp.in_ready", W'(in_ready), W'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp.drain", W'(out_valid), W'(0));
      check("bp.idle", W'(in_ready), W'(1));

      // Reset while calculating
      a        = 32'd100;
      b        = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst.in_ready_low", W'(in_ready), W'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst.out_valid", W'(out_valid), W'(0));
      check("midrst.in_ready", W'(in_ready), W'(1));
      check("midrst.quot", quot, W'(0));
      check("midrst.rem", rem, W'(0));
      run_op(32'd9, 32'd3, "after_rst");

      // Random operands with varied magnitudes and occasional zero divisor
      for (int n = 0; n < 40; n++) begin
         ra = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) ra = -ra;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = W'($urandom_range(0, 15)) - W'(8);
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 1) == 1) rb = -rb;
         run_op(ra, rb, $sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
